// File: rtl/reg_file.sv
// rtl/reg_file.sv - p18240 general-purpose register file with ZCNV condition-code register
// Two combinational read ports, one write port, optional same-cycle write forwarding.
module reg_file #(
   parameter int  NUM_REGS = 8,
   parameter int  WIDTH    = 16,
   parameter bit  BYPASS   = 1'b0,
   localparam int SELW     = $clog2(NUM_REGS)
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      wrEn,
   input  logic [SELW-1:0]           wrSel,
   input  logic [WIDTH-1:0]          wrData,
   input  logic [SELW-1:0]           rdSelA,
   input  logic [SELW-1:0]           rdSelB,
   output logic [WIDTH-1:0]          outA,
   output logic [WIDTH-1:0]          outB,
   input  logic                      ccLoad,
   input  logic [3:0]                ccIn,
   output logic [3:0]                ccOut,
   output logic [NUM_REGS*WIDTH-1:0] regView
);

   logic [WIDTH-1:0] regs_q [NUM_REGS];
   logic [WIDTH-1:0] regs_d [NUM_REGS];
   logic [3:0]       cc_q;
   logic [3:0]       cc_d;

   // Matching against every legal index means selects >= NUM_REGS never hit a register.
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         regs_d[i] = regs_q[i];
         if (wrEn && (wrSel == SELW'(i))) begin
            regs_d[i] = wrData;
         end
      end
      cc_d = ccLoad ? ccIn : cc_q;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
         cc_q <= 4'b0000;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
         cc_q <= cc_d;
      end
   end

   // Forwarding applies only to in-range selects, so it lives inside the index match.
   always_comb begin
      outA = '0;
      outB = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rdSelA == SELW'(i)) begin
            outA = (BYPASS && wrEn && (wrSel == SELW'(i))) ? wrData : regs_q[i];
         end
         if (rdSelB == SELW'(i)) begin
            outB = (BYPASS && wrEn && (wrSel == SELW'(i))) ? wrData : regs_q[i];
         end
      end
   end

   assign ccOut = cc_q;

   genvar g;
   generate
      for (g = 0; g < NUM_REGS; g++) begin : g_view
         assign regView[g*WIDTH +: WIDTH] = regs_q[g];
      end
   endgenerate

endmodule
